// File: rtl/pairhmm_pkg.sv
// Shared PairHMM read-side definitions: buffer read-port geometry and
// the stream reader state encodings.
package pairhmm_pkg;

  localparam int unsigned RD_WIDTH     = 48;
  localparam int unsigned RD_ADDRWIDTH = 10;
  localparam int unsigned RD_LENWIDTH  = RD_ADDRWIDTH + 1;

  typedef logic [1:0] rdState_t;

  localparam rdState_t IDLE = 2'd0;
  localparam rdState_t RUN  = 2'd1;
  localparam rdState_t DONE = 2'd2;

endpackage

// File: rtl/asym_ram_stream_reader_if.sv
// Valid/ready word stream from the reader to the systolic-array feed.
interface asym_ram_stream_reader_if
  import pairhmm_pkg::*;
#(
  parameter int unsigned WIDTH = RD_WIDTH
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/skid_fifo2.sv
// Depth-2 register FIFO; head register drives the stream directly.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  // Storage update; simultaneous push and pop keep the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else if (count == 2'd1) tail <= din;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else if (count == 2'd1) begin
            head <= din;
          end else begin
            head  <= din;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A push into a full FIFO without a matching pop would lose a word
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: rtl/asym_ram_stream_reader.sv
// Read sequencer: issues buffer reads, absorbs the 1-cycle read latency in
// a 2-entry skid FIFO and emits a valid/ready stream with m_last marking.
module asym_ram_stream_reader
  import pairhmm_pkg::*;
#(
  parameter int unsigned WIDTH     = RD_WIDTH,
  parameter int unsigned ADDRWIDTH = RD_ADDRWIDTH,
  parameter int unsigned LENWIDTH  = RD_LENWIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   start_addr,
  input  logic [LENWIDTH-1:0]    length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDRWIDTH-1:0]   ram_addr,
  input  logic [WIDTH-1:0]       ram_dout,
  asym_ram_stream_reader_if.master m
);

  rdState_t             state;
  logic [ADDRWIDTH-1:0] rdPtr;
  logic [LENWIDTH-1:0]  issueCnt;
  logic [LENWIDTH-1:0]  beatCnt;
  logic                 inflight;
  logic                 issue;
  logic                 pop;
  logic [1:0]           fifoCount;
  logic [2:0]           occ;
  logic                 lastBeat;

  assign pop      = m.valid & m.ready;
  assign lastBeat = beatCnt == LENWIDTH'(1);
  assign ram_addr = rdPtr;
  assign busy     = state == RUN;
  assign done     = state == DONE;
  assign m.valid  = fifoCount != 2'd0;
  assign m.last   = m.valid & lastBeat;

  // Issue when the FIFO plus the in-flight read, net of this cycle's pop,
  // leaves room; counting the pop lets reissue restart in the pop cycle
  always_comb begin
    occ   = {1'b0, fifoCount} + {2'b00, inflight} - {2'b00, pop};
    issue = (state == RUN) && (issueCnt != '0) && (occ < 3'd2);
  end

  // FSM, address pointer and the issue/beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdPtr    <= '0;
      issueCnt <= '0;
      beatCnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            rdPtr    <= start_addr;
            issueCnt <= length;
            beatCnt  <= length;
          end
        end
        RUN: begin
          if (issue) begin
            rdPtr    <= rdPtr + ADDRWIDTH'(1);
            issueCnt <= issueCnt - LENWIDTH'(1);
          end
          if (pop) beatCnt <= beatCnt - LENWIDTH'(1);
          if ((beatCnt == '0) || (pop && lastBeat)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  skid_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (ram_dout),
    .count (fifoCount),
    .head  (m.data)
  );

endmodule
